// File: rtl/jtkicker_gfx_arb.sv
// Graphics ROM slot arbiter: scroll and object fetchers share one SDRAM read slot,
// each backed by a one-word cache so repeated reads of the same address never touch the SDRAM.
module jtkicker_gfx_arb #(
  parameter int SCR_AW     = 13,
  parameter int OBJ_AW     = 14,
  parameter int ROM_AW     = 15,
  parameter int OBJ_OFFSET = 'h2000,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              scr_cs,
  input  logic [SCR_AW-1:0] scr_addr,
  output logic [31:0]       scr_data,
  output logic              scr_ok,

  input  logic              obj_cs,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [31:0]       obj_data,
  output logic              obj_ok,

  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              rom_ok,

  output logic              busy
);

  localparam int GAW = (SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW;
  localparam logic [ROM_AW-1:0] OBJ_OFS     = ROM_AW'(OBJ_OFFSET);
  localparam logic [7:0]        TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT
  } state_t;

  typedef enum logic {
    SEL_SCR,
    SEL_OBJ
  } sel_t;

  state_t            state, state_nxt;
  sel_t              gsel, last_grant;
  logic [GAW-1:0]    gaddr;
  logic [7:0]        timer;

  logic [31:0]       scr_cache, obj_cache;
  logic [SCR_AW-1:0] scr_tag;
  logic [OBJ_AW-1:0] obj_tag;
  logic              scr_vld, obj_vld;

  logic              scr_pend, obj_pend;
  logic              grant_scr, grant_obj;
  logic              fill, abandon;

  logic [ROM_AW-1:0] scr_rom_addr, obj_rom_addr;

  // Hit detection; ok is also held low while reset is asserted so the
  // requesters never see a stale hit during reset.
  assign scr_ok   = rst & scr_cs & scr_vld & (scr_tag == scr_addr);
  assign obj_ok   = rst & obj_cs & obj_vld & (obj_tag == obj_addr);
  assign scr_pend = scr_cs & ~scr_ok;
  assign obj_pend = obj_cs & ~obj_ok;

  assign scr_data = scr_cache;
  assign obj_data = obj_cache;
  assign busy     = (state != ST_IDLE);

  assign scr_rom_addr = ROM_AW'(scr_addr);
  assign obj_rom_addr = ROM_AW'(obj_addr) + OBJ_OFS;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and fetch sequencing. ARM exists only to skip the rom_ok
  // that the previous user of the slot may still be presenting.
  always_comb begin
    state_nxt = state;
    grant_scr = 1'b0;
    grant_obj = 1'b0;
    fill      = 1'b0;
    abandon   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scr_pend && obj_pend) begin
          if (last_grant == SEL_SCR) grant_obj = 1'b1;
          else                       grant_scr = 1'b1;
        end else if (scr_pend) begin
          grant_scr = 1'b1;
        end else if (obj_pend) begin
          grant_obj = 1'b1;
        end
        if (grant_scr || grant_obj) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rom_ok) begin
          fill      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer == TIMEOUT_CNT) begin
          abandon   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Slot request side: address and grant bookkeeping are captured at grant
  // and stay frozen for the whole fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      gaddr      <= '0;
      gsel       <= SEL_SCR;
      last_grant <= SEL_OBJ;
      timer      <= '0;
    end else begin
      if (grant_scr) begin
        rom_addr   <= scr_rom_addr;
        gaddr      <= GAW'(scr_addr);
        gsel       <= SEL_SCR;
        last_grant <= SEL_SCR;
      end else if (grant_obj) begin
        rom_addr   <= obj_rom_addr;
        gaddr      <= GAW'(obj_addr);
        gsel       <= SEL_OBJ;
        last_grant <= SEL_OBJ;
      end

      if (grant_scr || grant_obj) begin
        rom_cs <= 1'b1;
        timer  <= '0;
      end else if (fill || abandon) begin
        rom_cs <= 1'b0;
      end else if (state == ST_WAIT) begin
        timer  <= timer + 8'd1;
      end
    end
  end

  // Cache fill: the tag is the address that was granted, not whatever the
  // requester shows now, so a mid-fetch address change simply misses again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scr_cache <= '0;
      scr_tag   <= '0;
      scr_vld   <= 1'b0;
      obj_cache <= '0;
      obj_tag   <= '0;
      obj_vld   <= 1'b0;
    end else if (fill) begin
      if (gsel == SEL_SCR) begin
        scr_cache <= rom_data;
        scr_tag   <= gaddr[SCR_AW-1:0];
        scr_vld   <= 1'b1;
      end else begin
        obj_cache <= rom_data;
        obj_tag   <= gaddr[OBJ_AW-1:0];
        obj_vld   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_gfx_arb.sv
// Directed bench for jtkicker_gfx_arb: a cycle-by-cycle vector table covering
// misses, ties, hits and the stale-ok skip, then hand-written corner sequences.
module tb_jtkicker_gfx_arb;

  logic        clk;
  logic        rst;
  logic        scr_cs;
  logic [12:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [13:0] obj_addr;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic        rom_cs;
  logic [14:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic        busy;

  int checks = 0;
  int passes = 0;

  jtkicker_gfx_arb dut (
    .clk      (clk),
    .rst      (rst),
    .scr_cs   (scr_cs),
    .scr_addr (scr_addr),
    .scr_data (scr_data),
    .scr_ok   (scr_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .obj_ok   (obj_ok),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        sc;
    logic [12:0] sa;
    logic        oc;
    logic [13:0] oa;
    logic        rok;
    logic [31:0] rd;
    logic        e_rc;
    logic [14:0] e_ra;
    logic        e_busy;
    logic        e_sok;
    logic        e_ook;
    logic [31:0] e_sd;
    logic [31:0] e_od;
  } vec_t;

  localparam logic [31:0] DA = 32'hA0A0_0123;
  localparam logic [31:0] DB = 32'hB0B0_2010;
  localparam logic [31:0] DC = 32'hDEAD_BEEF;
  localparam logic [31:0] DD = 32'hD00D_1FFF;
  localparam logic [31:0] DE = 32'hE0E0_5FFF;
  localparam logic [31:0] DF = 32'hF0F0_0005;
  localparam logic [31:0] DG = 32'h6060_0010;
  localparam logic [31:0] DH = 32'h7070_0011;

  vec_t vecs[17];

  task automatic applyStimulus(input vec_t v);
    scr_cs   = v.sc;
    scr_addr = v.sa;
    obj_cs   = v.oc;
    obj_addr = v.oa;
    rom_ok   = v.rok;
    rom_data = v.rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the active edge, inputs change at the same point.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle table: tie from reset (scroll wins), obj follow-up,
    // hit, stale rom_ok during ARM, then a tie where obj wins.
    vecs[0]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b0, 32'h0, 1'b1, 15'h0123, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b0, 32'h0, 1'b1, 15'h0123, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b1, DA,    1'b0, 15'h0123, 1'b0, 1'b1, 1'b0, DA,    32'h0};
    vecs[3]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b0, 32'h0, 1'b1, 15'h2010, 1'b1, 1'b1, 1'b0, DA,    32'h0};
    vecs[4]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b0, 32'h0, 1'b1, 15'h2010, 1'b1, 1'b1, 1'b0, DA,    32'h0};
    vecs[5]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b1, DB,    1'b0, 15'h2010, 1'b0, 1'b1, 1'b1, DA,    DB};
    vecs[6]  = '{1'b1, 13'h0123, 1'b1, 14'h0010, 1'b0, 32'h0, 1'b0, 15'h2010, 1'b0, 1'b1, 1'b1, DA,    DB};
    vecs[7]  = '{1'b1, 13'h1FFF, 1'b0, 14'h0010, 1'b0, 32'h0, 1'b1, 15'h1FFF, 1'b1, 1'b0, 1'b0, DA,    DB};
    vecs[8]  = '{1'b1, 13'h1FFF, 1'b0, 14'h0010, 1'b1, DC,    1'b1, 15'h1FFF, 1'b1, 1'b0, 1'b0, DA,    DB};
    vecs[9]  = '{1'b1, 13'h1FFF, 1'b0, 14'h0010, 1'b1, DD,    1'b0, 15'h1FFF, 1'b0, 1'b1, 1'b0, DD,    DB};
    vecs[10] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b0, 32'h0, 1'b1, 15'h5FFF, 1'b1, 1'b0, 1'b0, DD,    DB};
    vecs[11] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b0, 32'h0, 1'b1, 15'h5FFF, 1'b1, 1'b0, 1'b0, DD,    DB};
    vecs[12] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b1, DE,    1'b0, 15'h5FFF, 1'b0, 1'b0, 1'b1, DD,    DE};
    vecs[13] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b0, 32'h0, 1'b1, 15'h0005, 1'b1, 1'b0, 1'b1, DD,    DE};
    vecs[14] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b0, 32'h0, 1'b1, 15'h0005, 1'b1, 1'b0, 1'b1, DD,    DE};
    vecs[15] = '{1'b1, 13'h0005, 1'b1, 14'h3FFF, 1'b1, DF,    1'b0, 15'h0005, 1'b0, 1'b1, 1'b1, DF,    DE};
    vecs[16] = '{1'b0, 13'h0005, 1'b0, 14'h3FFF, 1'b0, 32'h0, 1'b0, 15'h0005, 1'b0, 1'b0, 1'b0, DF,    DE};

    rst      = 1'b0;
    scr_cs   = 1'b0;
    scr_addr = '0;
    obj_cs   = 1'b0;
    obj_addr = '0;
    rom_ok   = 1'b0;
    rom_data = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset rom_cs",   32'(rom_cs),   32'h0);
    checkOutput("reset rom_addr", 32'(rom_addr), 32'h0);
    checkOutput("reset scr_ok",   32'(scr_ok),   32'h0);
    checkOutput("reset obj_ok",   32'(obj_ok),   32'h0);
    checkOutput("reset busy",     32'(busy),     32'h0);
    checkOutput("reset scr_data", scr_data,      32'h0);
    checkOutput("reset obj_data", obj_data,      32'h0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("v%0d rom_cs", i),   32'(rom_cs),   32'(vecs[i].e_rc));
      checkOutput($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_ra));
      checkOutput($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d scr_ok", i),   32'(scr_ok),   32'(vecs[i].e_sok));
      checkOutput($sformatf("v%0d obj_ok", i),   32'(obj_ok),   32'(vecs[i].e_ook));
      checkOutput($sformatf("v%0d scr_data", i), scr_data,      vecs[i].e_sd);
      checkOutput($sformatf("v%0d obj_data", i), obj_data,      vecs[i].e_od);
    end

    // Object address moves mid-fetch: fill lands under the old tag, then a second fetch.
    obj_cs = 1'b1; obj_addr = 14'h0010; rom_ok = 1'b0;
    stepCycle();
    checkOutput("t5 grant rom_cs",   32'(rom_cs),   32'h1);
    checkOutput("t5 grant rom_addr", 32'(rom_addr), 32'h2010);
    stepCycle();
    obj_addr = 14'h0011;
    stepCycle();
    checkOutput("t5 frozen rom_addr", 32'(rom_addr), 32'h2010);
    checkOutput("t5 wait obj_ok",     32'(obj_ok),   32'h0);
    rom_ok = 1'b1; rom_data = DG;
    stepCycle();
    checkOutput("t5 fill rom_cs",   32'(rom_cs),   32'h0);
    checkOutput("t5 fill obj_ok",   32'(obj_ok),   32'h0);
    checkOutput("t5 fill obj_data", obj_data,      DG);
    rom_ok = 1'b0; rom_data = '0;
    stepCycle();
    checkOutput("t5 refetch rom_cs",   32'(rom_cs),   32'h1);
    checkOutput("t5 refetch rom_addr", 32'(rom_addr), 32'h2011);
    stepCycle();
    rom_ok = 1'b1; rom_data = DH;
    stepCycle();
    checkOutput("t5 second obj_ok",   32'(obj_ok), 32'h1);
    checkOutput("t5 second obj_data", obj_data,    DH);
    rom_ok = 1'b0; rom_data = '0; obj_cs = 1'b0;
    stepCycle();

    // Timeout: rom_ok never comes; rom_cs must stay high for TIMEOUT+2 cycles.
    scr_cs = 1'b1; scr_addr = 13'h0AAA;
    stepCycle();
    checkOutput("t6 grant rom_cs", 32'(rom_cs), 32'h1);
    begin
      int n;
      n = 0;
      for (int k = 0; k < 400; k++) begin
        stepCycle();
        n++;
        if (rom_cs == 1'b0) break;
      end
      checkOutput("t6 timeout cycles", 32'(n), 32'd257);
    end
    checkOutput("t6 timeout scr_ok", 32'(scr_ok), 32'h0);
    checkOutput("t6 timeout busy",   32'(busy),   32'h0);
    checkOutput("t6 timeout cache",  scr_data,    DF);
    stepCycle();
    checkOutput("t6 rearb rom_cs", 32'(rom_cs), 32'h1);
    stepCycle();
    stepCycle();
    checkOutput("t6 wait busy", 32'(busy), 32'h1);
    rst = 1'b0;
    stepCycle();
    checkOutput("t6 reset rom_cs",   32'(rom_cs), 32'h0);
    checkOutput("t6 reset scr_ok",   32'(scr_ok), 32'h0);
    checkOutput("t6 reset obj_ok",   32'(obj_ok), 32'h0);
    checkOutput("t6 reset busy",     32'(busy),   32'h0);
    checkOutput("t6 reset scr_data", scr_data,    32'h0);
    scr_cs = 1'b0;
    stepCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
